// File: rtl/jtag_spi_pkg.sv
// Shared types and constants for the JTAG-to-SPI flash bridge monitor.
// Holds the state encoding, the flash opcodes it knows about and the debug-word field positions.
package jtag_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OPCODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4
  } state_t;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_STATUS    = 8'hD7;
  localparam logic [7:0] OP_ID        = 8'h9F;
  localparam logic [7:0] OP_PAGE_READ = 8'hD2;
  localparam logic [7:0] OP_CONT_READ = 8'hE8;

  localparam int DBG_STATE_LSB     = 29;
  localparam int DBG_CS_ACT        = 28;
  localparam int DBG_FRAME_DONE    = 27;
  localparam int DBG_BYTE_VALID    = 26;
  localparam int DBG_PARTIAL_ERR   = 25;
  localparam int DBG_OPCODE_LSB    = 16;
  localparam int DBG_LAST_BYTE_LSB = 8;
  localparam int DBG_BYTE_CNT_LSB  = 0;

  // Opcodes whose payload comes back from the flash rather than from the host.
  function automatic logic is_read_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_FAST_READ) || (op == OP_STATUS) ||
           (op == OP_ID) || (op == OP_PAGE_READ) || (op == OP_CONT_READ);
  endfunction

  function automatic logic is_noaddr_op(input logic [7:0] op);
    return (op == OP_STATUS) || (op == OP_ID);
  endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// STAGES-deep synchronizer with rise/fall detect; q lags d by STAGES cycles, edges are combinational on q.
// Passive, no backpressure.
module jtag_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_l,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_d;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      sync <= '0;
      q_d  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/jtag_spi_monitor.sv
// Passive SPI flash frame decoder on the JTAG USER chain; decoded bytes appear SYNC_STAGES+2 cycles after the DRCK pin edge.
// Observation only: no backpressure, never drives the SPI path.
module jtag_spi_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_BYTES  = 3
) (
  input  logic        FPGA_24MHZ_CLK,
  input  logic        rst_l,
  input  logic        sel_in,
  input  logic        shift_in,
  input  logic        drck_in,
  input  logic        tdi_in,
  input  logic        tdo_in,
  output logic [31:0] jtag2spi_dbg,
  output logic [23:0] spi_addr,
  output logic [15:0] frame_count
);
  import jtag_spi_pkg::*;

  localparam int ACW = $clog2(ADDR_BYTES + 1);

  logic [4:0] pins, syn, rise_v, fall_v;
  assign pins = {sel_in, shift_in, drck_in, tdi_in, tdo_in};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (FPGA_24MHZ_CLK),
      .rst_l(rst_l),
      .d    (pins[i]),
      .q    (syn[i]),
      .rise (rise_v[i]),
      .fall (fall_v[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{rise_v[4:3], rise_v[1:0], fall_v};

  logic cs_act, cs_act_d, cs_rise, cs_fall, drck_rise;
  assign cs_act    = syn[4] & syn[3];
  assign cs_rise   = cs_act & ~cs_act_d;
  assign cs_fall   = ~cs_act & cs_act_d;
  assign drck_rise = rise_v[2];

  state_t           state;
  logic [7:0]       mosi_sr, miso_sr, opcode, last_byte, byte_cnt;
  logic [2:0]       bit_cnt;
  logic [15:0]      addr_sr;
  logic [ACW-1:0]   addr_cnt;
  logic             byte_done, byte_valid, frame_done, partial_err;

  always_ff @(posedge FPGA_24MHZ_CLK) begin
    if (!rst_l) begin
      state       <= ST_IDLE;
      cs_act_d    <= 1'b0;
      mosi_sr     <= '0;
      miso_sr     <= '0;
      opcode      <= '0;
      last_byte   <= '0;
      byte_cnt    <= '0;
      bit_cnt     <= '0;
      addr_sr     <= '0;
      addr_cnt    <= '0;
      byte_done   <= 1'b0;
      byte_valid  <= 1'b0;
      frame_done  <= 1'b0;
      partial_err <= 1'b0;
      spi_addr    <= '0;
      frame_count <= '0;
    end else begin
      cs_act_d   <= cs_act;
      byte_done  <= 1'b0;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      // Frame end wins over everything: a coincident DRCK rise and any pending byte are dropped.
      if (state != ST_IDLE && cs_fall) begin
        state       <= ST_IDLE;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
        partial_err <= (bit_cnt != 3'd0);
      end else begin
        if (state == ST_IDLE && cs_rise) begin
          state       <= ST_OPCODE;
          bit_cnt     <= '0;
          byte_cnt    <= '0;
          last_byte   <= '0;
          partial_err <= 1'b0;
        end else if (state != ST_IDLE && cs_act && drck_rise) begin
          mosi_sr   <= {mosi_sr[6:0], syn[1]};
          miso_sr   <= {miso_sr[6:0], syn[0]};
          bit_cnt   <= bit_cnt + 3'd1;
          byte_done <= (bit_cnt == 3'd7);
        end
        // Shift registers hold the full byte one cycle after its last bit.
        if (byte_done) begin
          case (state)
            ST_OPCODE: begin
              opcode <= mosi_sr;
              if (is_noaddr_op(mosi_sr)) begin
                state <= ST_DATA;
              end else begin
                state    <= ST_ADDR;
                addr_cnt <= '0;
              end
            end
            ST_ADDR: begin
              addr_sr  <= {addr_sr[7:0], mosi_sr};
              addr_cnt <= addr_cnt + ACW'(1);
              if (addr_cnt == ACW'(ADDR_BYTES - 1)) begin
                spi_addr <= {addr_sr, mosi_sr};
                state    <= (opcode == OP_FAST_READ) ? ST_DUMMY : ST_DATA;
              end
            end
            ST_DUMMY: state <= ST_DATA;
            ST_DATA: begin
              byte_valid <= 1'b1;
              last_byte  <= is_read_op(opcode) ? miso_sr : mosi_sr;
              if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    jtag2spi_dbg = '0;
    jtag2spi_dbg[DBG_STATE_LSB +: 3]     = state;
    jtag2spi_dbg[DBG_CS_ACT]             = cs_act_d;
    jtag2spi_dbg[DBG_FRAME_DONE]         = frame_done;
    jtag2spi_dbg[DBG_BYTE_VALID]         = byte_valid;
    jtag2spi_dbg[DBG_PARTIAL_ERR]        = partial_err;
    jtag2spi_dbg[DBG_OPCODE_LSB +: 8]    = opcode;
    jtag2spi_dbg[DBG_LAST_BYTE_LSB +: 8] = last_byte;
    jtag2spi_dbg[DBG_BYTE_CNT_LSB +: 8]  = byte_cnt;
  end

endmodule

// File: tb/tb_jtag_spi_monitor.sv
// Self-checking bench for jtag_spi_monitor: frame-level reference model plus directed corner cases.
`timescale 1ns/1ps
module tb_jtag_spi_monitor;
  localparam int SYNC_STAGES = 2;
  localparam int ADDR_BYTES  = 3;

  logic clk = 1'b0, rst_l = 1'b0, sel = 1'b0, shift = 1'b0, drck = 1'b0, tdi = 1'b0, tdo = 1'b0;
  logic [31:0] dbg;
  logic [23:0] spi_addr;
  logic [15:0] frame_count;

  always #20 clk = ~clk;

  jtag_spi_monitor #(.SYNC_STAGES(SYNC_STAGES), .ADDR_BYTES(ADDR_BYTES)) dut (
    .FPGA_24MHZ_CLK(clk),
    .rst_l         (rst_l),
    .sel_in        (sel),
    .shift_in      (shift),
    .drck_in       (drck),
    .tdi_in        (tdi),
    .tdo_in        (tdo),
    .jtag2spi_dbg  (dbg),
    .spi_addr      (spi_addr),
    .frame_count   (frame_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] last;
    logic [7:0] cnt;
  } exp_byte_t;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] addr;
    logic [7:0]  cnt;
    logic [7:0]  last;
    logic        partial;
    logic [15:0] count;
    logic        addr_vis;
    logic        dummy_vis;
  } exp_frame_t;

  exp_byte_t  byte_q[$];
  exp_frame_t frame_q[$];

  // Stimulus for the next frame: whole bytes, extra trailing bits, and an optional
  // final DRCK rise that lands together with shift dropping.
  logic [7:0] mosi_q[$];
  logic [7:0] miso_q[$];
  int         tail = 0;
  bit         coincide = 1'b0;

  logic [7:0]  m_opcode = '0;
  logic [23:0] m_addr = '0;
  int          m_count = 0;

  function automatic bit is_read(input logic [7:0] op);
    return op inside {8'h03, 8'h0B, 8'hD7, 8'h9F, 8'hD2, 8'hE8};
  endfunction

  task automatic model_frame();
    exp_frame_t f;
    exp_byte_t  b;
    int n, hdr, nd;
    bit noaddr;
    n = mosi_q.size();
    if (n > 0) m_opcode = mosi_q[0];
    noaddr = (m_opcode == 8'hD7) || (m_opcode == 8'h9F);
    hdr = noaddr ? 1 : 1 + ADDR_BYTES + ((m_opcode == 8'h0B) ? 1 : 0);
    if (!noaddr && n >= 1 + ADDR_BYTES) m_addr = {mosi_q[1], mosi_q[2], mosi_q[3]};
    nd = 0;
    f.last = 8'h00;
    for (int i = hdr; i < n; i++) begin
      nd++;
      b.last = is_read(m_opcode) ? miso_q[i] : mosi_q[i];
      b.cnt  = (nd > 255) ? 8'd255 : 8'(nd);
      byte_q.push_back(b);
      f.last = b.last;
    end
    m_count++;
    f.op        = m_opcode;
    f.addr      = m_addr;
    f.cnt       = (nd > 255) ? 8'd255 : 8'(nd);
    f.partial   = (tail != 0);
    f.count     = 16'(m_count);
    f.addr_vis  = (n >= 1) && !noaddr;
    f.dummy_vis = (m_opcode == 8'h0B) && (n >= 1 + ADDR_BYTES);
    frame_q.push_back(f);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period is four core clocks: the 6 MHz worst case.
  task automatic drive_bit(input logic m, input logic s, input bit drop_cs);
    tdi = m; tdo = s; drck = 1'b0;
    tick(2);
    drck = 1'b1;
    if (drop_cs) shift = 1'b0;
    tick(2);
  endtask

  logic start_partial, start_cs;

  task automatic run_frame();
    model_frame();
    @(negedge clk);
    sel = 1'b1; shift = 1'b1; drck = 1'b0;
    tick(4);
    start_partial = dbg[25];
    start_cs      = dbg[28];
    for (int i = 0; i < mosi_q.size(); i++)
      for (int k = 7; k >= 0; k--) drive_bit(mosi_q[i][k], miso_q[i][k], 1'b0);
    for (int k = 0; k < tail; k++) drive_bit(1'($urandom), 1'($urandom), 1'b0);
    if (coincide) drive_bit(1'($urandom), 1'($urandom), 1'b1);
    drck = 1'b0;
    tick(2);
    shift = 1'b0;
    if ($urandom_range(0, 1) == 1) sel = 1'b0;
    tick(8);
  endtask

  task automatic set_frame(input int n, input logic [7:0] op);
    mosi_q.delete(); miso_q.delete();
    for (int i = 0; i < n; i++) begin
      mosi_q.push_back(8'($urandom));
      miso_q.push_back(8'($urandom));
    end
    mosi_q[0] = op;
    tail = 0; coincide = 1'b0;
  endtask

  exp_byte_t  cb;
  exp_frame_t cf;
  bit vis_addr = 1'b0, vis_dummy = 1'b0;
  int bv_count = 0, fd_count = 0;

  always @(negedge clk) begin
    if (!rst_l) begin
      vis_addr = 1'b0; vis_dummy = 1'b0;
    end else begin
      if (dbg[31:29] == 3'd2) vis_addr = 1'b1;
      if (dbg[31:29] == 3'd3) vis_dummy = 1'b1;
      if (dbg[26]) begin
        bv_count++;
        check("byte_valid_expected", 32'(byte_q.size() != 0), 32'd1);
        if (byte_q.size() != 0) begin
          cb = byte_q.pop_front();
          check("last_byte", dbg[15:8], cb.last);
          check("byte_cnt_run", dbg[7:0], cb.cnt);
        end
      end
      if (dbg[27]) begin
        fd_count++;
        check("frame_done_expected", 32'(frame_q.size() != 0), 32'd1);
        if (frame_q.size() != 0) begin
          cf = frame_q.pop_front();
          check("frame_state", dbg[31:29], 32'd0);
          check("frame_opcode", dbg[23:16], cf.op);
          check("frame_addr", spi_addr, cf.addr);
          check("frame_byte_cnt", dbg[7:0], cf.cnt);
          check("frame_last_byte", dbg[15:8], cf.last);
          check("frame_partial", dbg[25], cf.partial);
          check("frame_count", frame_count, cf.count);
          check("addr_visited", vis_addr, cf.addr_vis);
          check("dummy_visited", vis_dummy, cf.dummy_vis);
          check("bytes_outstanding", byte_q.size(), 32'd0);
        end
        vis_addr = 1'b0; vis_dummy = 1'b0;
      end
    end
  end

  initial begin
    int bv0, fd0, n, hdr;
    logic [7:0] op;
    logic [7:0] ops [8] = '{8'h03, 8'h0B, 8'hD7, 8'h9F, 8'hD2, 8'hE8, 8'h02, 8'h82};

    rst_l = 1'b0;
    tick(4);
    check("reset_dbg", dbg, 32'h0);
    check("reset_addr", spi_addr, 32'h0);
    check("reset_count", frame_count, 32'h0);
    rst_l = 1'b1;
    tick(2);

    // Reset held for three cycles in the middle of an addressed frame.
    sel = 1'b1; shift = 1'b1;
    tick(4);
    for (int k = 7; k >= 0; k--) drive_bit(k[0], 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) drive_bit(1'b1, 1'b0, 1'b0);
    drck = 1'b0;
    tick(4);
    check("midframe_state_addr", dbg[31:29], 32'd2);
    rst_l = 1'b0;
    tick(3);
    check("midreset_dbg", dbg, 32'h0);
    check("midreset_addr", spi_addr, 32'h0);
    check("midreset_count", frame_count, 32'h0);
    sel = 1'b0; shift = 1'b0;
    tick(4);
    rst_l = 1'b1;
    tick(4);
    m_opcode = '0; m_addr = '0; m_count = 0;

    // Read ID: no address phase, three MISO bytes.
    set_frame(4, 8'h9F);
    miso_q[1] = 8'h1F; miso_q[2] = 8'h24; miso_q[3] = 8'h00;
    bv0 = bv_count; fd0 = fd_count;
    run_frame();
    check("id_opcode", dbg[23:16], 32'h9F);
    check("id_last", dbg[15:8], 32'h00);
    check("id_cnt", dbg[7:0], 32'd3);
    check("id_pulses", bv_count - bv0, 32'd3);
    check("id_frames", fd_count - fd0, 32'd1);
    check("id_frame_count", frame_count, 32'd1);
    check("id_cs_seen", start_cs, 32'd1);

    // Fast read with dummy byte.
    set_frame(7, 8'h0B);
    mosi_q[1] = 8'h01; mosi_q[2] = 8'h23; mosi_q[3] = 8'h45; mosi_q[4] = 8'hFF;
    miso_q[5] = 8'hA5; miso_q[6] = 8'h5A;
    run_frame();
    check("fr_addr", spi_addr, 32'h012345);
    check("fr_cnt", dbg[7:0], 32'd2);
    check("fr_last", dbg[15:8], 32'h5A);

    // Long host-write payload saturates the byte counter.
    set_frame(304, 8'h82);
    mosi_q[1] = 8'h00; mosi_q[2] = 8'h01; mosi_q[3] = 8'h00;
    for (int i = 4; i < 304; i++) mosi_q[i] = 8'h3C;
    run_frame();
    check("sat_cnt", dbg[7:0], 32'd255);
    check("sat_last", dbg[15:8], 32'h3C);
    check("sat_addr", spi_addr, 32'h000100);

    // Status read cut off mid-byte.
    set_frame(2, 8'hD7);
    miso_q[1] = 8'h6E;
    tail = 4;
    fd0 = fd_count;
    run_frame();
    check("part_err", dbg[25], 32'd1);
    check("part_cnt", dbg[7:0], 32'd1);
    check("part_last", dbg[15:8], 32'h6E);
    check("part_frames", fd_count - fd0, 32'd1);

    // Eighth bit of a byte arrives with the frame end and must be ignored.
    set_frame(2, 8'h9F);
    miso_q[1] = 8'hC3;
    tail = 7; coincide = 1'b1;
    run_frame();
    check("next_start_clears_err", start_partial, 32'd0);
    check("coinc_err", dbg[25], 32'd1);
    check("coinc_cnt", dbg[7:0], 32'd1);
    check("coinc_state", dbg[31:29], 32'd0);
    check("coinc_count", frame_count, 32'd5);

    for (int t = 0; t < 24; t++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 5) == 0) op = 8'($urandom);
      hdr = (op == 8'hD7 || op == 8'h9F) ? 1 : ((op == 8'h0B) ? 5 : 4);
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, hdr) : hdr + $urandom_range(0, 5);
      set_frame(n, op);
      if ($urandom_range(0, 2) == 0) tail = $urandom_range(1, 7);
      run_frame();
    end

    check("frames_outstanding", frame_q.size(), 32'd0);
    check("bytes_left_end", byte_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
